i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
Shares the single i2c_master_controller between NREQ requesters, e.g. the ROM config sequencer and a runtime status/register poller.
- Accepts one write transaction (address byte, sub-address, data) per grant.
- Drives the master's request/field inputs and tracks its busy signal through the transaction.
- Returns a completion or timeout pulse to the owning requester.
- Sits between the requesters and i2c_master_controller; no change to the master.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 255, max clk cycles in WAIT_BUSY for i2c_busy to rise before abort
TW, 8, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester transaction request, level, held until gnt
req_addr_w_rw  in  8*NREQ  per-requester slave address byte, LSB = R/W (0 = write); slice i = bits [8i+7:8i]
req_sub_addr  in  8*NREQ  per-requester sub-address
req_data_write  in  8*NREQ  per-requester write data
gnt  out  NREQ  one-hot one-cycle pulse: fields of that requester latched
done  out  NREQ  one-hot one-cycle pulse: transaction completed
err  out  NREQ  one-hot one-cycle pulse: master never went busy (timeout)
i2c_busy  in  1  busy from i2c_master_controller
o_addr_w_rw  out  8  to master
o_sub_addr  out  8  to master
o_data_write  out  8  to master
req_trans  out  1  transaction request to master
owner  out  $clog2(NREQ)  index of current/last granted requester

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous, active-low, on reset_n.
- Reset values:
  - Outputs: gnt, done, err, req_trans = 0; o_* = 8'h00; owner = 0.
  - State: FSM = IDLE; round-robin pointer last = NREQ-1, so requester 0 wins first; timeout counter = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If |req && !i2c_busy, select the winner: first set req bit scanning from last+1 upward, wrapping modulo NREQ.
  - On that edge: latch the winner's three fields into o_*; gnt[w] = 1 for one cycle; owner = w; last = w; go to ISSUE.
  - If i2c_busy = 1, stay in IDLE with no grant, even if req is set.
- ISSUE: req_trans = 1; timer = 0; go to WAIT_BUSY.
- WAIT_BUSY:
  - req_trans held at 1; timer increments each cycle.
  - On i2c_busy = 1: req_trans = 0, go to WAIT_DONE.
  - Else if timer == TIMEOUT: req_trans = 0, err[owner] = 1 for one cycle, go to GAP.
  - If busy and timeout coincide, busy wins.
- WAIT_DONE: on i2c_busy = 0, done[owner] = 1 for one cycle, go to GAP.
- GAP: one idle cycle so a requester can drop or re-raise req after done; then go to IDLE.
- o_* hold their values from grant until the next grant; they never change while req_trans or i2c_busy is high.
- Latency: req rise (master idle) to gnt = 1 clk; gnt to req_trans = 1 clk. Minimum grant-to-grant spacing, excluding master time, = 5 clk.
- Requester contract:
  - Fields are sampled only on the grant edge.
  - Deasserting req before its gnt withdraws the request; this is legal.
  - Holding req after gnt queues a new transaction, arbitrated fairly in the next IDLE.
- Fairness: with all req held, grants rotate 0,1,...,NREQ-1,0.
- Reset mid-transaction: immediate return to reset values; req_trans drops asynchronously. No done/err is issued for the aborted transaction.
- Unused requester slots (req tied 0) are never granted.

Optional Feature:
Macro I2C_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority. In IDLE, if req[0] = 1 it wins regardless of last. Remaining requesters use round-robin among themselves; last is updated only by non-zero grants.
- Not defined: pure round-robin as above.

Test Plan:
- Single requester 0 (addr 8'hB8, sub 8'h02, data 8'h11); master model raises busy 3 clk after req_trans and holds it 20 clk. Expect: gnt[0] next clk; req_trans high for 4 clk; o_* = B8/02/11; done[0] exactly 1 clk after busy falls.
- req = 2'b11 held continuously, master completes each transaction. Expect grant order 0,1,0,1; no gnt while busy; exactly one done per gnt.
- Master model never asserts busy, TIMEOUT = 255. Expect err[owner] 256 clk after req_trans rises; req_trans = 0; no done; next request still served.
- i2c_busy held 1 externally when req[1] rises. Expect no gnt until busy = 0, then gnt[1] on the next clk.
- reset_n pulsed low during WAIT_DONE. Expect req_trans = 0 immediately; all outputs at reset values; no done/err; after release the first grant goes to requester 0.
- With I2C_ARB_PRIORITY_EN defined and req = 2'b11 held: every grant goes to requester 0. Drop req[0]: requester 1 is granted next.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master_controller between NREQ requesters, one write transaction per grant.
// Round-robin by default; define I2C_ARB_PRIORITY_EN to give requester 0 strict priority.
module i2c_txn_arbiter #(
  parameter  int NREQ    = 2,
  parameter  int TIMEOUT = 255,
  parameter  int TW      = 8,
  localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr_w_rw,
  input  logic [8*NREQ-1:0] req_sub_addr,
  input  logic [8*NREQ-1:0] req_data_write,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  input  logic              i2c_busy,
  output logic [7:0]        o_addr_w_rw,
  output logic [7:0]        o_sub_addr,
  output logic [7:0]        o_data_write,
  output logic              req_trans,
  output logic [OW-1:0]     owner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [OW-1:0]     r_last;
  logic [OW-1:0]     r_owner;
  logic [TW-1:0]     r_timer;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [NREQ-1:0]   r_err;
  logic              r_req_trans;
  logic [7:0]        r_addr;
  logic [7:0]        r_sub;
  logic [7:0]        r_data;

  logic              w_found;
  logic [OW-1:0]     w_win;
  logic [OW-1:0]     w_idx;

  // Scan upward from the slot after the last winner, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = OW'((int'(r_last) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`ifdef I2C_ARB_PRIORITY_EN
    if (req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_last      <= OW'(NREQ - 1);
      r_owner     <= '0;
      r_timer     <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_req_trans <= 1'b0;
      r_addr      <= 8'h00;
      r_sub       <= 8'h00;
      r_data      <= 8'h00;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found && !i2c_busy) begin
            r_addr       <= req_addr_w_rw[int'(w_win)*8 +: 8];
            r_sub        <= req_sub_addr[int'(w_win)*8 +: 8];
            r_data       <= req_data_write[int'(w_win)*8 +: 8];
            r_gnt[w_win] <= 1'b1;
            r_owner      <= w_win;
`ifdef I2C_ARB_PRIORITY_EN
            // Requester 0 wins outright, so it must not disturb the rotation of the others.
            if (w_win != '0) r_last <= w_win;
`else
            r_last       <= w_win;
`endif
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_req_trans <= 1'b1;
          r_timer     <= '0;
          r_state     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_timer <= r_timer + 1'b1;
          if (i2c_busy) begin
            r_req_trans <= 1'b0;
            r_state     <= S_WAIT_DONE;
          end else if (r_timer == TW'(TIMEOUT)) begin
            r_req_trans    <= 1'b0;
            r_err[r_owner] <= 1'b1;
            r_state        <= S_GAP;
          end
        end
        S_WAIT_DONE: begin
          if (!i2c_busy) begin
            r_done[r_owner] <= 1'b1;
            r_state         <= S_GAP;
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign done         = r_done;
  assign err          = r_err;
  assign req_trans    = r_req_trans;
  assign o_addr_w_rw  = r_addr;
  assign o_sub_addr   = r_sub;
  assign o_data_write = r_data;
  assign owner        = r_owner;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: vector table plus directed sequences, with a
// grant/outcome scoreboard and a simple i2c master busy model.
module tb_i2c_txn_arbiter;
  localparam int NREQ    = 2;
  localparam int M_DELAY = 3;
  localparam int M_HOLD  = 20;
`ifdef I2C_ARB_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] f_addr = '0, f_sub = '0, f_data = '0;
  logic [1:0]  gnt, done, err;
  logic        i2c_busy;
  logic [7:0]  o_addr, o_sub, o_data;
  logic        req_trans;
  logic        owner;

  logic        m_busy = 1'b0, force_busy = 1'b0, m_respond = 1'b1;
  logic [1:0]  m_state = 2'd0;
  int          m_cnt = 0;

  assign i2c_busy = m_busy | force_busy;

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(255), .TW(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .req_addr_w_rw(f_addr), .req_sub_addr(f_sub), .req_data_write(f_data),
    .gnt(gnt), .done(done), .err(err), .i2c_busy(i2c_busy),
    .o_addr_w_rw(o_addr), .o_sub_addr(o_sub), .o_data_write(o_data),
    .req_trans(req_trans), .owner(owner)
  );

  always #5 clk = ~clk;

  // Master model: busy rises M_DELAY clocks after req_trans, stays high M_HOLD clocks.
  always @(posedge clk) begin
    case (m_state)
      2'd0: if (req_trans && m_respond) begin m_cnt <= 1; m_state <= 2'd1; end
      2'd1: if (m_cnt == M_DELAY - 1) begin m_busy <= 1'b1; m_cnt <= 1; m_state <= 2'd2; end
            else m_cnt <= m_cnt + 1;
      default: if (m_cnt == M_HOLD) begin m_busy <= 1'b0; m_state <= 2'd0; end
               else m_cnt <= m_cnt + 1;
    endcase
  end

  typedef struct { int idx; logic [7:0] a; logic [7:0] s; logic [7:0] d; bit is_err; } exp_t;
  typedef struct {
    logic [1:0] req;
    logic [7:0] a0, s0, d0, a1, s1, d1;
    bit respond; int exp_idx; bit exp_err;
  } vec_t;

  exp_t sb[$];
  exp_t pend;
  bit   pend_valid = 1'b0;
  int   n_out = 0, n_checks = 0, n_fail = 0;
  int   tgt, lat, rt, fall, dk, outcnt, widx;
  bit   bp, stable;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (!reset_n) begin pend_valid = 1'b0; return; end
    if (|gnt) begin
      if (sb.size() == 0) chk("sb_gnt_unexpected", 32'(gnt), 0);
      else begin
        e = sb.pop_front();
        chk("sb_gnt", 32'(gnt), 32'(1) << e.idx);
        chk("sb_owner", 32'(owner), 32'(e.idx));
        chk("sb_addr", 32'(o_addr), 32'(e.a));
        chk("sb_sub", 32'(o_sub), 32'(e.s));
        chk("sb_data", 32'(o_data), 32'(e.d));
        chk("sb_busy_at_gnt", 32'(i2c_busy), 0);
        pend = e;
        pend_valid = 1'b1;
      end
    end
    if (|done || |err) begin
      if (!pend_valid) chk("sb_outcome_unexpected", 32'({done, err}), 0);
      else begin
        chk("sb_done", 32'(done), pend.is_err ? 32'd0 : (32'(1) << pend.idx));
        chk("sb_err", 32'(err), pend.is_err ? (32'(1) << pend.idx) : 32'd0);
        pend_valid = 1'b0;
        n_out++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic wait_gnt(input int budget);
    int k = 0;
    do begin tick(); k++; end while (!(|gnt) && k < budget);
    chk("wait_gnt", 32'(|gnt), 1);
  endtask

  task automatic wait_out(input int target, input int budget);
    int k = 0;
    do begin tick(); k++; end while (n_out < target && k < budget);
    chk("wait_outcome", 32'(n_out >= target), 1);
  endtask

  task automatic set_fields(input int i, input logic [7:0] a, input logic [7:0] s, input logic [7:0] d);
    f_addr[8*i +: 8] = a;
    f_sub[8*i +: 8]  = s;
    f_data[8*i +: 8] = d;
  endtask

  task automatic push_exp(input int i, input logic [7:0] a, input logic [7:0] s, input logic [7:0] d, input bit e);
    exp_t x;
    x.idx = i; x.a = a; x.s = s; x.d = d; x.is_err = e;
    sb.push_back(x);
  endtask

  initial begin
    tbl[0] = '{2'b01, 8'hB8, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0};
    tbl[1] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'hA0, 8'h10, 8'h22, 1'b1, 1, 1'b0};
    tbl[2] = '{2'b11, 8'h40, 8'h41, 8'h42, 8'h50, 8'h51, 8'h52, 1'b1, 0, 1'b0};
    tbl[3] = '{2'b11, 8'h43, 8'h44, 8'h45, 8'h53, 8'h54, 8'h55, 1'b1, PRI ? 0 : 1, 1'b0};
    tbl[4] = '{2'b11, 8'h46, 8'h47, 8'h48, 8'h56, 8'h57, 8'h58, 1'b1, 0, 1'b0};
    tbl[5] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5B, 8'h5C, 1'b1, 1, 1'b0};
    tbl[6] = '{2'b01, 8'h70, 8'h71, 8'h72, 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b1};
    tbl[7] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'h7A, 8'h7B, 8'h7C, 1'b1, 1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req_trans", 32'(req_trans), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_sub", 32'(o_sub), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_owner", 32'(owner), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      m_respond = tbl[i].respond;
      set_fields(0, tbl[i].a0, tbl[i].s0, tbl[i].d0);
      set_fields(1, tbl[i].a1, tbl[i].s1, tbl[i].d1);
      if (tbl[i].exp_idx == 0) push_exp(0, tbl[i].a0, tbl[i].s0, tbl[i].d0, tbl[i].exp_err);
      else                     push_exp(1, tbl[i].a1, tbl[i].s1, tbl[i].d1, tbl[i].exp_err);
      tgt = n_out + 1;
      req = tbl[i].req;
      wait_gnt(20);
      chk("tbl_gnt", 32'(gnt), 32'(1) << tbl[i].exp_idx);
      req = 2'b00;
      lat = 0;
      do begin tick(); lat++; end while (n_out < tgt && lat < 400);
      chk("tbl_outcome", 32'(n_out), 32'(tgt));
      if (tbl[i].exp_err) begin
        chk("tbl_err_latency", 32'(lat), 257);
        chk("tbl_err_req_trans", 32'(req_trans), 0);
      end
      tick(); tick();
    end
    m_respond = 1'b1;

    // Continuous requests: rotation (or priority), then requester 1 alone.
    set_fields(0, 8'h90, 8'h91, 8'h92);
    set_fields(1, 8'hA0, 8'hA1, 8'hA2);
    for (int g = 0; g < 5; g++) begin
      widx = (g == 4) ? 1 : (PRI ? 0 : g % 2);
      if (widx == 0) push_exp(0, 8'h90, 8'h91, 8'h92, 1'b0);
      else           push_exp(1, 8'hA0, 8'hA1, 8'hA2, 1'b0);
    end
    tgt = n_out + 5;
    req = 2'b11;
    for (int g = 0; g < 4; g++) wait_gnt(60);
    req = 2'b10;
    wait_gnt(60);
    req = 2'b00;
    wait_out(tgt, 100);
    tick(); tick();

    // Single requester timing: latency, req_trans width, done after busy falls, stable fields.
    set_fields(0, 8'hB8, 8'h02, 8'h11);
    push_exp(0, 8'hB8, 8'h02, 8'h11, 1'b0);
    tgt = n_out + 1;
    req = 2'b01;
    tick();
    chk("s1_gnt_latency", 32'(gnt), 1);
    req = 2'b00;
    rt = 0; fall = -1; dk = -1; bp = i2c_busy; stable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1) chk("s1_gnt_pulse", 32'(gnt), 0);
      rt += int'(req_trans);
      if (bp && !i2c_busy && fall < 0) fall = k;
      bp = i2c_busy;
      if (done[0] && dk < 0) dk = k;
      if (o_addr !== 8'hB8 || o_sub !== 8'h02 || o_data !== 8'h11) stable = 1'b0;
    end
    chk("s1_req_trans_width", 32'(rt), 4);
    chk("s1_done_after_busy", 32'(dk), 32'(fall + 1));
    chk("s1_fields_stable", 32'(stable), 1);
    chk("s1_outcome", 32'(n_out), 32'(tgt));

    // Master busy held externally: no grant until it drops.
    set_fields(1, 8'hE0, 8'hE1, 8'hE2);
    push_exp(1, 8'hE0, 8'hE1, 8'hE2, 1'b0);
    tgt = n_out + 1;
    force_busy = 1'b1;
    req = 2'b10;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("s2_no_gnt_busy", 32'(gnt), 0);
    end
    force_busy = 1'b0;
    tick();
    chk("s2_gnt_after_busy", 32'(gnt), 2);
    req = 2'b00;
    wait_out(tgt, 60);
    tick(); tick();

    // Reset during WAIT_DONE.
    set_fields(0, 8'hC0, 8'hC1, 8'hC2);
    set_fields(1, 8'hD0, 8'hD1, 8'hD2);
    push_exp(0, 8'hC0, 8'hC1, 8'hC2, 1'b0);
    req = 2'b01;
    wait_gnt(20);
    req = 2'b00;
    for (int k = 0; k < 20 && !i2c_busy; k++) tick();
    tick(); tick();
    outcnt = n_out;
    #2 reset_n = 1'b0;
    #1;
    chk("s3_req_trans", 32'(req_trans), 0);
    chk("s3_gnt", 32'(gnt), 0);
    chk("s3_done_err", 32'({done, err}), 0);
    chk("s3_addr", 32'(o_addr), 0);
    chk("s3_sub", 32'(o_sub), 0);
    chk("s3_data", 32'(o_data), 0);
    chk("s3_owner", 32'(owner), 0);
    tick(); tick();
    reset_n = 1'b1;
    push_exp(0, 8'hC0, 8'hC1, 8'hC2, 1'b0);
    req = 2'b11;
    wait_gnt(100);
    chk("s3_first_gnt", 32'(gnt), 1);
    req = 2'b00;
    wait_out(outcnt + 1, 60);
    chk("s3_single_outcome", 32'(n_out), 32'(outcnt + 1));
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
